// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: groups the FIFO read-side signals and the outgoing
// valid/ready stream of fifo_rd_stream into one bundle.
//   master : the fifo_rd_stream block (drives FIFO_RD_EN and the stream)
//   slave  : the environment (FIFO read port plus stream consumer)
interface fifo_rd_stream_if #(
    parameter int C_WIDTH = 32
);
    logic               FIFO_RD_EN;
    logic               FIFO_EMPTY;
    logic [C_WIDTH-1:0] FIFO_DATA;
    logic [C_WIDTH-1:0] DATA;
    logic               VALID;
    logic               READY;
    logic [1:0]         COUNT;

    modport master (
        output FIFO_RD_EN,
        output DATA,
        output VALID,
        output COUNT,
        input  FIFO_EMPTY,
        input  FIFO_DATA,
        input  READY
    );

    modport slave (
        input  FIFO_RD_EN,
        input  DATA,
        input  VALID,
        input  COUNT,
        output FIFO_EMPTY,
        output FIFO_DATA,
        output READY
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side companion of the async FIFO, entirely in the FIFO
// read clock domain. Issues FIFO reads (data returns one cycle after RD_EN),
// captures returned words into a 3-entry circular prefetch buffer and presents
// the head as a valid/ready stream. READY never reaches FIFO_RD_EN: reads are
// issued purely from buffer occupancy (held + in flight) and FIFO_EMPTY.
//
// Optional feature: define FIFO_RD_STREAM_STATS_EN to add the STATS_CLR input
// and the saturating WORDS_OUT / STALL_CYCLES counters. The datapath is the
// same with or without it.

// fifo_rd_stream_chk: occupancy sanity checks, kept out of the datapath.
module fifo_rd_stream_chk (
    input logic       CLK,
    input logic       RST_N,
    input logic [1:0] count_r,
    input logic       inflight_r,
    input logic       pop_s
);
    // Held plus in-flight words must never exceed the three buffer slots.
    always @(posedge CLK) begin
        if (RST_N) begin
            assert ({1'b0, count_r} + {2'b00, inflight_r} <= 3'd3)
                else $error("fifo_rd_stream: buffer occupancy exceeds 3");
            assert (!(pop_s && (count_r == 2'd0)))
                else $error("fifo_rd_stream: pop from empty buffer");
        end
    end
endmodule

module fifo_rd_stream #(
    parameter int C_WIDTH     = 32
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    parameter int C_CNT_WIDTH = 32
`endif
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    fifo_rd_stream_if.master       bus
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    input  logic                   STATS_CLR,
    output logic [C_CNT_WIDTH-1:0] WORDS_OUT,
    output logic [C_CNT_WIDTH-1:0] STALL_CYCLES
`endif
);

    // Circular pointer advance over the three slots: 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        logic [1:0] n;
        if (p == 2'd2) begin
            n = 2'd0;
        end else begin
            n = p + 2'd1;
        end
        return n;
    endfunction

    logic [C_WIDTH-1:0] mem_r [0:2];
    logic [1:0]         count_r;
    logic [1:0]         head_r;
    logic [1:0]         tail_r;
    logic               inflight_r;

    logic [2:0]         occ_s;
    logic               rd_en_s;
    logic               push_s;
    logic               pop_s;
    logic               valid_s;
    logic [1:0]         count_nxt_s;
    logic [C_WIDTH-1:0] head_data_s;

    // Read issue: room for one more word counting the one already in flight.
    // RST_N gates the enable so no read is issued while reset is held.
    always_comb begin
        occ_s   = {1'b0, count_r} + {2'b00, inflight_r};
        rd_en_s = 1'b0;
        if (RST_N && !bus.FIFO_EMPTY && (occ_s < 3'd3)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Buffer handshakes: a word lands whenever a read was issued last cycle
    // (FIFO_EMPTY is irrelevant by then); a word leaves on VALID && READY.
    always_comb begin
        valid_s = (count_r != 2'd0);
        push_s  = inflight_r;
        pop_s   = valid_s && bus.READY;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // Head slot selection for the stream data output.
    always_comb begin
        case (head_r)
            2'd0:    head_data_s = mem_r[0];
            2'd1:    head_data_s = mem_r[1];
            2'd2:    head_data_s = mem_r[2];
            default: head_data_s = mem_r[0];
        endcase
    end

    // Buffer state: in-flight flag, occupancy, pointers and storage slots.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            inflight_r <= 1'b0;
            count_r    <= 2'd0;
            head_r     <= 2'd0;
            tail_r     <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                mem_r[i] <= {C_WIDTH{1'b0}};
            end
        end else begin
            inflight_r <= rd_en_s;
            count_r    <= count_nxt_s;
            if (push_s) begin
                for (int i = 0; i < 3; i++) begin
                    if (tail_r == 2'(i)) begin
                        mem_r[i] <= bus.FIFO_DATA;
                    end
                end
                tail_r <= ptr_inc(tail_r);
            end
            if (pop_s) begin
                head_r <= ptr_inc(head_r);
            end
        end
    end

    assign bus.FIFO_RD_EN = rd_en_s;
    assign bus.VALID      = valid_s;
    assign bus.DATA       = head_data_s;
    assign bus.COUNT      = count_r;

`ifdef FIFO_RD_STREAM_STATS_EN
    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = {C_CNT_WIDTH{1'b1}};

    logic [C_CNT_WIDTH-1:0] words_r;
    logic [C_CNT_WIDTH-1:0] stalls_r;

    // Transfer and stall counters; clear wins over increment, both saturate.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            words_r  <= {C_CNT_WIDTH{1'b0}};
            stalls_r <= {C_CNT_WIDTH{1'b0}};
        end else if (STATS_CLR) begin
            words_r  <= {C_CNT_WIDTH{1'b0}};
            stalls_r <= {C_CNT_WIDTH{1'b0}};
        end else begin
            if (pop_s && (words_r != CNT_MAX)) begin
                words_r <= words_r + CNT_ONE;
            end
            if (valid_s && !bus.READY && (stalls_r != CNT_MAX)) begin
                stalls_r <= stalls_r + CNT_ONE;
            end
        end
    end

    assign WORDS_OUT    = words_r;
    assign STALL_CYCLES = stalls_r;
`endif

    fifo_rd_stream_chk u_chk (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .count_r    (count_r),
        .inflight_r (inflight_r),
        .pop_s      (pop_s)
    );

endmodule
